mult_div_unit: RTL and testbench

Parametrised multicycle multiply/divide unit with HI/LO result registers. The main control unit drives it through a start/busy/done handshake for MULT, DIV and their unsigned forms, and reads results through MFHI/MFLO. It supersedes the fixed-width MultCtrl/MultOut and DivCtrl/DivOut/divZero hookup. It adds width generalisation, unsigned mode, direct HI/LO writes and a clean divide-by-zero path.

---
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes; signs are applied in a final fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_op;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_dz;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic [WIDTH:0]         r_acc_hi;
  logic [WIDTH-1:0]       r_acc_lo;
  logic [WIDTH-1:0]       r_opb;

  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction

  logic                   w_sa;
  logic                   w_sb;
  logic                   w_div_zero_req;
  logic [WIDTH:0]         w_madd;
  logic [WIDTH:0]         w_dshift;
  logic [WIDTH:0]         w_ddiff;
  logic                   w_qbit;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;

  assign w_sa           = i_sgn & i_a[WIDTH-1];
  assign w_sb           = i_sgn & i_b[WIDTH-1];
  assign w_div_zero_req = i_op & (i_b == '0);

  assign w_madd   = r_acc_lo[0] ? (r_acc_hi + {1'b0, r_opb}) : r_acc_hi;
  // Remainder stays below the divisor, so a borrow out of bit WIDTH means "does not fit".
  assign w_dshift = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_opb};
  assign w_qbit   = ~w_ddiff[WIDTH];

  assign w_prod = f_cneg2({r_acc_hi[WIDTH-1:0], r_acc_lo}, r_neg_q);
  assign w_quo  = f_cneg(r_acc_lo, r_neg_q);
  assign w_rem  = f_cneg(r_acc_hi[WIDTH-1:0], r_neg_r);

  // Iteration datapath: accumulator and operand magnitudes carry no reset
  always_ff @(posedge i_clk) begin
    if (r_state == IDLE && i_start && !w_div_zero_req) begin
      r_acc_hi <= '0;
      r_acc_lo <= f_cneg(i_a, w_sa);
      r_opb    <= f_cneg(i_b, w_sb);
    end else if (r_state == ITER) begin
      if (r_op) begin
        r_acc_hi <= w_qbit ? w_ddiff : w_dshift;
        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_qbit};
      end else begin
        {r_acc_hi, r_acc_lo} <= {1'b0, w_madd, r_acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Control FSM and architectural HI/LO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_div_zero_req) begin
              r_done <= 1'b1;
              r_dz   <= 1'b1;
            end else begin
              r_op    <= i_op;
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= w_sa;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ITER;
            end
          end else begin
            if (i_wr_hi) r_hi <= i_wdata;
            if (i_wr_lo) r_lo <= i_wdata;
          end
        end
        ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_op) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_dz;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH 8, 16 and 32 against an integer-arithmetic model.
module tb_mult_div_unit;

  typedef struct {
    int          idx;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    int          bcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op, sgn;
  logic [31:0] a_in, b_in, wdata;
  logic        start_v [3];
  logic        wr_hi_v [3];
  logic        wr_lo_v [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        dz_w    [3];
  logic [31:0] hi_w    [3];
  logic [31:0] lo_w    [3];
  logic [7:0]  hi8, lo8;
  logic [15:0] hi16, lo16;
  logic [31:0] hi32, lo32;

  int          WW [3] = '{8, 16, 32};
  int          sel;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          busy_cnt [3];
  logic [31:0] mhi [3];
  logic [31:0] mlo [3];
  exp_t        q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_div_unit #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]), .i_op(op), .i_sgn(sgn),
    .i_a(a_in[7:0]), .i_b(b_in[7:0]), .i_wr_hi(wr_hi_v[0]), .i_wr_lo(wr_lo_v[0]),
    .i_wdata(wdata[7:0]), .o_busy(busy_w[0]), .o_done(done_w[0]), .o_div_zero(dz_w[0]),
    .o_hi(hi8), .o_lo(lo8));

  mult_div_unit #(.WIDTH(16)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]), .i_op(op), .i_sgn(sgn),
    .i_a(a_in[15:0]), .i_b(b_in[15:0]), .i_wr_hi(wr_hi_v[1]), .i_wr_lo(wr_lo_v[1]),
    .i_wdata(wdata[15:0]), .o_busy(busy_w[1]), .o_done(done_w[1]), .o_div_zero(dz_w[1]),
    .o_hi(hi16), .o_lo(lo16));

  mult_div_unit #(.WIDTH(32)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[2]), .i_op(op), .i_sgn(sgn),
    .i_a(a_in), .i_b(b_in), .i_wr_hi(wr_hi_v[2]), .i_wr_lo(wr_lo_v[2]),
    .i_wdata(wdata), .o_busy(busy_w[2]), .o_done(done_w[2]), .o_div_zero(dz_w[2]),
    .o_hi(hi32), .o_lo(lo32));

  assign hi_w[0] = {24'd0, hi8};
  assign lo_w[0] = {24'd0, lo8};
  assign hi_w[1] = {16'd0, hi16};
  assign lo_w[1] = {16'd0, lo16};
  assign hi_w[2] = hi32;
  assign lo_w[2] = lo32;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Reference: plain integer arithmetic on the signed/unsigned interpretations.
  function automatic logic [63:0] model(input int w, input bit o, input bit s,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q_, r_;
    logic [63:0] p;
    logic [31:0] m;
    m  = mask_of(w);
    sa = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (!o) begin
      p = 64'(sa * sb);
      return {32'((p >> w)) & m, p[31:0] & m};
    end
    q_ = sa / sb;
    r_ = sa % sb;
    return {32'(r_) & m, 32'(q_) & m};
  endfunction

  task automatic issue(input bit o, input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          w;
    logic [63:0] r;
    w = WW[sel];
    a = a & mask_of(w);
    b = b & mask_of(w);
    @(posedge clk); #1;
    e.idx = sel;
    e.dz  = o && (b == 0);
    if (e.dz) begin
      e.hi = mhi[sel]; e.lo = mlo[sel]; e.due = cyc + 1; e.bcnt = 0;
    end else begin
      r = model(w, o, s, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.due = cyc + w + 2; e.bcnt = w + 1;
      mhi[sel] = e.hi; mlo[sel] = e.lo;
    end
    q.push_back(e);
    op = o; sgn = s; a_in = a; b_in = b;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    a_in = $urandom; b_in = $urandom; op = $urandom_range(0, 1); sgn = $urandom_range(0, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    if (q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL timeout: no done on width %0d within %0d cycles", WW[sel], limit);
      q.delete();
    end
  endtask

  task automatic wr(input bit h, input bit l, input logic [31:0] d);
    @(posedge clk); #1;
    wr_hi_v[sel] = h; wr_lo_v[sel] = l; wdata = d;
    @(posedge clk); #1;
    wr_hi_v[sel] = 1'b0; wr_lo_v[sel] = 1'b0; wdata = $urandom;
    if (h) mhi[sel] = d & mask_of(WW[sel]);
    if (l) mlo[sel] = d & mask_of(WW[sel]);
    chk("wr_hi", hi_w[sel], mhi[sel]);
    chk("wr_lo", lo_w[sel], mlo[sel]);
  endtask

  // Monitor: pops on every done pulse, checks result, timing and busy duration.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          busy_cnt[i] = 0;
        end else begin
          if (busy_w[i]) busy_cnt[i]++;
          if (dz_w[i] && !done_w[i]) chk("dz_without_done", 32'(dz_w[i]), 32'd0);
          if (done_w[i]) begin
            if (q.size() == 0 || q[0].idx != i) begin
              chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
            end else begin
              e = q.pop_front();
              chk("hi", hi_w[i], e.hi);
              chk("lo", lo_w[i], e.lo);
              chk("div_zero", 32'(dz_w[i]), 32'(e.dz));
              chk("latency", 32'(cyc), 32'(e.due));
              chk("busy_cycles", 32'(busy_cnt[i]), 32'(e.bcnt));
              chk("busy_at_done", 32'(busy_w[i]), 32'd0);
            end
            busy_cnt[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] m, mn, ra, rb;
    rst_n = 1'b0; op = 0; sgn = 0; a_in = 0; b_in = 0; wdata = 0; sel = 0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 0; wr_hi_v[i] = 0; wr_lo_v[i] = 0; mhi[i] = 0; mlo[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_hi", hi_w[i], 32'd0);
      chk("rst_lo", lo_w[i], 32'd0);
      chk("rst_busy", 32'(busy_w[i]), 32'd0);
      chk("rst_done", 32'(done_w[i]), 32'd0);
      chk("rst_dz", 32'(dz_w[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 2; s >= 0; s--) begin
      sel = s;
      m   = mask_of(WW[s]);
      mn  = 32'd1 << (WW[s] - 1);
      issue(0, 1, 32'hFFFF_FFFD, 32'd7);           wait_idle(60);
      issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_idle(60);
      issue(1, 1, 32'hFFFF_FFF9, 32'd2);           wait_idle(60);
      issue(1, 0, 32'hFFFF_FFF9, 32'd2);           wait_idle(60);
      issue(1, 1, mn, 32'hFFFF_FFFF);              wait_idle(60);
      if (s == 2) begin
        chk("ovf_lo_const", lo_w[2], 32'h8000_0000);
        chk("ovf_hi_const", hi_w[2], 32'd0);
      end
      wr(1, 1, 32'h0000_1234);
      wr(0, 1, 32'h0000_5678);
      issue(1, $urandom_range(0, 1), $urandom, 32'd0); wait_idle(60);
      chk("dz_keeps_hi", hi_w[s], 32'h1234 & m);
      chk("dz_keeps_lo", lo_w[s], 32'h5678 & m);

      // Second start and a direct write while busy must not disturb the result.
      issue(0, 1, $urandom, $urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_mid", 32'(busy_w[s]), 32'd1);
      start_v[s] = 1'b1; wr_lo_v[s] = 1'b1; wdata = $urandom; op = 1; b_in = 0;
      @(posedge clk); #1;
      start_v[s] = 1'b0; wr_lo_v[s] = 1'b0;
      wait_idle(60);
      wr(1, 1, $urandom);

      for (int k = 0; k < 40; k++) begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
          0: rb = 0;
          1: rb = $urandom_range(1, 5);
          2: ra = mn;
          3: rb = 32'hFFFF_FFFF;
          default: ;
        endcase
        issue($urandom_range(0, 1), $urandom_range(0, 1), ra, rb);
        wait_idle(60);
      end

      // Asynchronous reset partway through a multiply discards it.
      issue(0, 1, $urandom, $urandom);
      repeat (s == 0 ? 5 : 10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      q.delete();
      for (int i = 0; i < 3; i++) begin mhi[i] = 0; mlo[i] = 0; end
      #1;
      chk("arst_hi", hi_w[s], 32'd0);
      chk("arst_lo", lo_w[s], 32'd0);
      chk("arst_busy", 32'(busy_w[s]), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (WW[s] + 4) @(posedge clk);
      #1;
      chk("no_done_after_rst", hi_w[s], 32'd0);
      issue(0, 1, 32'hFFFF_FFFD, 32'd7); wait_idle(60);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
